// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one fifo write port in bursts of
// up to MAX_BURST beats, with writes gated combinationally by fifo_full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_din,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [15:0]                beat_total
);

  localparam int          ID_W  = $clog2(N_REQ);
  localparam int          CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned NR    = N_REQ;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       total_q;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   next_owner;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    logic            found;
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    sel   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx  = (32'(ptr_q) + k) % NR;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign next_owner = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          owner_d = sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        req_ready[owner_q] = !fifo_full;
        fifo_wr_en         = req_valid[owner_q] & !fifo_full;
        fifo_din           = req_data[owner_q*DATA_W +: DATA_W];
        // A full FIFO freezes the grant entirely, including the release check.
        if (!fifo_full) begin
          if (!req_valid[owner_q] || cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = next_owner;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (fifo_wr_en) total_q <= total_q + 16'd1;
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_id    = owner_q;
  assign beat_total  = total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues, a depth-16 FIFO model,
// and a scoreboard of expected {grant_id, data} beats and FIFO read-back data.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_din;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [15:0]     beat_total;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .grant_valid(grant_valid), .grant_id(grant_id),
    .beat_total(beat_total)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] pq [N][$];
  logic [9:0] exp_q [$];
  logic [7:0] rd_exp [$];
  logic [7:0] fq [$];

  logic rd = 1'b0, rd_chk = 1'b0, drive_model = 1'b1;
  logic [N-1:0] acc_s = '0;
  logic wr_s = 1'b0, rd_s = 1'b0;
  logic [7:0] din_s = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    fifo_full = (fq.size() >= 16);
    if (drive_model) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (pq[i].size() != 0);
        req_data[i*W +: W] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
      end
    end
  endtask

  // One clock: commit sampled handshakes at the edge, drive at +1, check at negedge.
  task automatic step();
    logic [9:0] e;
    logic [7:0] d;
    @(posedge clk);
    if (rst) begin
      fq.delete();
    end else begin
      for (int i = 0; i < N; i++) if (acc_s[i]) void'(pq[i].pop_front());
      if (rd_s) begin
        d = fq.pop_front();
        if (rd_chk) begin
          if (rd_exp.size() == 0) begin
            tests++; fails++;
            $error("FAIL rd_unexpected: observed %0h expected none", d);
          end else begin
            chk("rd_data", d, rd_exp.pop_front());
          end
        end
      end
      if (wr_s) fq.push_back(din_s);
    end
    #1;
    drive_inputs();
    @(negedge clk);
    if (fifo_wr_en === 1'b1) begin
      chk("no_overflow", fifo_full, 0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL beat_unexpected: observed id %0d data %0h expected none", grant_id, fifo_din);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {grant_id, fifo_din}, e);
      end
    end
    chk("ready", req_ready, (grant_valid && !fifo_full) ? (4'b0001 << grant_id) : 4'b0000);
    chk("wr_en", fifo_wr_en, grant_valid & req_valid[grant_id] & ~fifo_full);
    acc_s = req_valid & req_ready;
    wr_s  = fifo_wr_en;
    din_s = fifo_din;
    rd_s  = rd && (fq.size() != 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    rd_exp.delete();
    acc_s = '0; wr_s = 1'b0; rd_s = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_model();
    fq.delete();
    req_valid = '0; req_data = '0;
    drive_model = 1'b1; rd = 1'b0; rd_chk = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_wr"}, fifo_wr_en, 0);
    chk({tag, "_din"}, fifo_din, 0);
    chk({tag, "_gv"}, grant_valid, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_total"}, beat_total, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    // Reset with random inputs
    rst = 1'b1;
    drive_model = 1'b0;
    fq.delete();
    fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      step();
      chk_zero("rst");
    end
    rst = 1'b0;
    drive_model = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("rst_idle_gv", grant_valid, 0);
    chk("rst_idle_total", beat_total, 0);

    // Single producer
    reset_dut();
    for (int v = 8'h11; v <= 8'h13; v++) begin
      pq[1].push_back(8'(v));
      exp_q.push_back({2'd1, 8'(v)});
      rd_exp.push_back(8'(v));
    end
    step();
    chk("sp_idle0", grant_valid, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("sp_wr", fifo_wr_en, 1);
      chk("sp_id", grant_id, 1);
    end
    step();
    chk("sp_rel_gv", grant_valid, 1);
    chk("sp_rel_wr", fifo_wr_en, 0);
    step();
    chk("sp_idle", grant_valid, 0);
    chk("sp_id_held", grant_id, 1);
    chk("sp_total", beat_total, 3);
    rd = 1'b1; rd_chk = 1'b1;
    for (int c = 0; c < 4; c++) step();
    rd = 1'b0;
    chk("sp_readback", rd_exp.size(), 0);
    chk("sp_scoreboard", exp_q.size(), 0);

    // Fairness: all producers valid, FIFO drained every cycle
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) pq[i].push_back(8'(i*16 + j));
    for (int g = 0; g < N; g++)
      for (int j = 0; j < MB; j++) exp_q.push_back({2'(g), 8'(g*16 + j)});
    exp_q.push_back({2'd0, 8'h04});
    rd = 1'b1;
    for (int k = 0; k < 22; k++) begin
      step();
      if (k == 0) begin
        chk("fair_idle0", grant_valid, 0);
      end else begin
        m = (k - 1) % 5;
        chk("fair_gv", grant_valid, (m < 4) ? 1 : 0);
        if (m < 4) chk("fair_id", grant_id, ((k - 1) / 5) % 4);
      end
    end
    chk("fair_total", beat_total, 16);
    chk("fair_scoreboard", exp_q.size(), 0);

    // Full stall: producer 2 streams 0x01..0x14 with no reads
    reset_dut();
    for (int v = 1; v <= 20; v++) begin
      pq[2].push_back(8'(v));
      exp_q.push_back({2'd2, 8'(v)});
      rd_exp.push_back(8'(v));
    end
    rd_chk = 1'b1;
    n = 0;
    while (fifo_full !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    chk("fs_full_seen", fifo_full, 1);
    chk("fs_total16", beat_total, 16);
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("fs_stall_gv", grant_valid, 1);
      chk("fs_stall_wr", fifo_wr_en, 0);
      chk("fs_stall_ready2", req_ready[2], 0);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
    chk("fs_one_beat", fifo_wr_en, 1);
    chk("fs_one_din", fifo_din, 8'h11);
    step();
    chk("fs_refull_wr", fifo_wr_en, 0);
    chk("fs_refull_gv", grant_valid, 1);
    chk("fs_total17", beat_total, 17);
    rd = 1'b1;
    for (int c = 0; c < 40; c++) step();
    rd = 1'b0;
    chk("fs_drain", rd_exp.size(), 0);
    chk("fs_scoreboard", exp_q.size(), 0);
    chk("fs_total20", beat_total, 20);

    // Early release: producer 0 drops after 2 beats, search from 1 picks 3
    reset_dut();
    pq[0].push_back(8'hA0); pq[0].push_back(8'hA1);
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'hA1});
    for (int j = 0; j < 4; j++) begin
      pq[3].push_back(8'(8'hD0 + j));
      exp_q.push_back({2'd3, 8'(8'hD0 + j)});
    end
    rd = 1'b1;
    step();
    chk("er_idle0", grant_valid, 0);
    step();
    step();
    chk("er_id0", grant_id, 0);
    step();
    chk("er_rel_gv", grant_valid, 1);
    chk("er_rel_wr", fifo_wr_en, 0);
    step();
    chk("er_bubble", grant_valid, 0);
    step();
    chk("er_gv3", grant_valid, 1);
    chk("er_id3", grant_id, 3);
    chk("er_wr3", fifo_wr_en, 1);
    for (int c = 0; c < 4; c++) step();
    chk("er_scoreboard", exp_q.size(), 0);
    chk("er_total", beat_total, 6);

    // Reset mid-burst, then ptr restarts at 0
    reset_dut();
    for (int v = 8'h21; v <= 8'h23; v++) pq[2].push_back(8'(v));
    exp_q.push_back({2'd2, 8'h21}); exp_q.push_back({2'd2, 8'h22});
    rd = 1'b1;
    step();
    step();
    step();
    chk("mr_second_beat", fifo_wr_en, 1);
    rst = 1'b1;
    #1;
    chk_zero("mr");
    clear_model();
    pq[3].push_back(8'h31);
    pq[0].push_back(8'h01);
    exp_q.push_back({2'd0, 8'h01});
    exp_q.push_back({2'd3, 8'h31});
    step();
    rst = 1'b0;
    step();
    chk("mr_first_id", grant_id, 0);
    chk("mr_first_wr", fifo_wr_en, 1);
    step();
    step();
    step();
    chk("mr_second_id", grant_id, 3);
    chk("mr_second_wr", fifo_wr_en, 1);
    step();
    chk("mr_scoreboard", exp_q.size(), 0);
    chk("mr_total", beat_total, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that lets N producers share the write port of the team's single-clock `fifo` (8-bit, depth 16, `full`/`empty` flags). Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time, for bursts of up to `MAX_BURST` beats, and drives the FIFO's `wr_en`/`din` directly, gated by `full`. It sits between the producer blocks and the `fifo` instance; the read side is untouched.

## Interface
- `N_REQ`, default 4: number of producers (2..8).
- `DATA_W`, default 8: data width; matches `fifo` `din`.
- `MAX_BURST`, default 4: maximum beats per grant (1..16).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  producer i has a beat on its slice of `req_data`.
- `req_data`  in  N_REQ*DATA_W  producer i data in bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  producer i beat accepted this cycle when valid&ready.
- `fifo_full`  in  1  `full` from the `fifo`.
- `fifo_wr_en`  out  1  to `fifo` `wr_en`.
- `fifo_din`  out  DATA_W  to `fifo` `din`.
- `grant_valid`  out  1  a producer currently owns the port.
- `grant_id`  out  clog2(N_REQ)  index of the owner.
- `beat_total`  out  16  running count of accepted beats; wraps 0xFFFF->0.

## Operation
- Registered state: `state` (IDLE/GRANT), `owner`, `ptr` (round-robin start), `beat_cnt` (0..MAX_BURST-1), `beat_total`.
- IDLE: if any `req_valid` is set, select the first set bit searching from `ptr` upward, modulo N_REQ. At the next edge: state goes to GRANT, `owner` takes the selected index, `beat_cnt` is cleared. If no `req_valid` is set, stay in IDLE.
- GRANT, combinational outputs:
  - `req_ready[owner] = !fifo_full`.
  - All other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[owner] & !fifo_full`.
  - `fifo_din = req_data[owner]`.
- In IDLE: `req_ready = 0`, `fifo_wr_en = 0`, `fifo_din = 0`.
- Beat = `fifo_wr_en` high at the edge. Each beat increments `beat_total`.
- Release: return to IDLE and set `ptr = owner+1` (mod N_REQ) in either case:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[owner]` is low in a GRANT cycle (no beat).
- Otherwise a beat increments `beat_cnt`.
- Full stall: while `fifo_full` is high, the grant is held, `beat_cnt` is frozen, and there is no release.
- At most one beat per cycle. The arbiter never writes while `fifo_full` is high, so it never overflows the FIFO.
- `grant_valid = (state == GRANT)`; `grant_id = owner`, held after release until the next grant.
- Reset (async, any time): state IDLE, `owner` = 0, `ptr` = 0, `beat_cnt` = 0, `beat_total` = 0. All outputs are then 0: `req_ready`, `fifo_wr_en`, `fifo_din`, `grant_valid`, `grant_id`, `beat_total`. Reset mid-burst abandons the burst; no beat is counted for that cycle.

## Timing
- Arbitration latency: if `req_valid` is first seen at edge E0, E0 registers the grant, the first `fifo_wr_en` is high in the cycle after E0, and the first beat commits at E1.
- Burst: one beat per cycle while valid and not full. A full uninterrupted burst occupies the port for MAX_BURST cycles followed by one IDLE bubble.
- Back-to-back grants have exactly one IDLE cycle between them.
- `fifo_full` to `fifo_wr_en` is a combinational path with zero latency. `fifo_full` must come directly from the `fifo` register, with no extra pipeline stage.
- A FIFO read in the same cycle as full does not enable a write until `fifo_full` deasserts (conservative, matches `fifo` semantics).
- Producers may change data only after valid&ready, or while valid is low.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> all outputs 0; after release with no valid, stays IDLE and `beat_total` = 0.
- Single producer: `req_valid[1]` for beats 0x11, 0x12, 0x13, then low -> one bubble; `grant_id` = 1; three consecutive `fifo_wr_en` cycles with `fifo_din` 0x11, 0x12, 0x13; `beat_total` = 3; FIFO reads back 0x11, 0x12, 0x13; IDLE the cycle after valid drops.
- Fairness: all 4 producers valid continuously, MAX_BURST = 4, FIFO drained every cycle -> grant order 0, 1, 2, 3, 0; 4 beats each; exactly one IDLE cycle between grants; `beat_total` = 16 after four grants.
- Full stall: producer 2 streams 0x01..0x14 with no reads -> writes 0x01..0x10; `fifo_full` rises; `fifo_wr_en` = 0 and `req_ready[2]` = 0 while `grant_valid` stays 1. One read then allows exactly one beat, 0x11. Draining yields 0x01..0x11 in order with no loss and no duplicates.
- Early release: producers 0 and 3 valid, producer 0 drops valid after 2 beats -> IDLE for one cycle, then `grant_id` = 3 with `ptr` = 1. The search from 1 selects 3.
- Reset mid-burst: `rst` pulsed during the 2nd beat of producer 2 -> outputs 0 immediately; after release with producers 3 and 0 valid, producer 0 is granted first because `ptr` = 0.
